board_frame_buffer: RTL and testbench

- Double-buffered Tetris board store sitting directly upstream of the LED matrix controller.
- Game logic edits the back buffer cell by cell. The LED controller reads whole rows from the front buffer.
- Buffers swap only at a frame boundary reported by the LED controller, so a displayed frame never tears.
- Also publishes full-row flags for line-clear scoring.

---
 rtl/board_frame_buffer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_board_frame_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_frame_buffer.sv
// ---------------------------------------------------------------------------
// board_frame_buffer
//
// Double-buffered Tetris board store that feeds the LED matrix controller.
// Game logic edits the back buffer one cell at a time. The LED controller
// reads whole rows from the front buffer. Front and back change places only
// at a frame boundary reported by the LED controller, so a displayed frame
// never tears. Per-row "full" flags of the back buffer are published for
// line-clear scoring.
//
// Optional feature (macro ROW_COLLAPSE_EN):
//   Adds a row-collapse engine. It removes every full row of the back buffer,
//   shifts the remaining rows down and fills the top with empty rows.
//   Without the macro the collapse ports do not exist and the FSM has only
//   IDLE and CLEAR.
//
// Ports:
//   clk            in   rising-edge system clock
//   reset          in   synchronous, active-high reset
//   wr_en          in   write one back-buffer cell this cycle
//   wr_row         in   row of the write (0 = top)
//   wr_col         in   column of the write
//   wr_val         in   cell value, 1 = occupied
//   clr_start      in   pulse: clear the whole back buffer
//   collapse_start in   pulse: collapse full rows (ROW_COLLAPSE_EN only)
//   busy           out  clear or collapse in progress
//   swap_req       in   level: request a front/back swap, held until swap_ack
//   frame_done     in   pulse from the LED controller at end of frame scan
//   swap_ack       out  one-cycle pulse: swap performed
//   front_sel      out  index of the buffer currently displayed
//   rd_row         in   front-buffer row requested by the LED controller
//   rd_data        out  registered front-buffer row, bit i = column i
//   full_rows      out  bit r = 1 when back-buffer row r is fully occupied
//   lines_cleared  out  rows removed by the last collapse (ROW_COLLAPSE_EN only)
// ---------------------------------------------------------------------------

`default_nettype none

module board_frame_buffer #(
    parameter int WIDTH    = 10,
    parameter int HEIGHT   = 20,
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] wr_row,
    input  logic [COL_BITS-1:0] wr_col,
    input  logic                wr_val,
    input  logic                clr_start,
`ifdef ROW_COLLAPSE_EN
    input  logic                collapse_start,
    output logic [ROW_BITS-1:0] lines_cleared,
`endif
    output logic                busy,
    input  logic                swap_req,
    input  logic                frame_done,
    output logic                swap_ack,
    output logic                front_sel,
    input  logic [ROW_BITS-1:0] rd_row,
    output logic [WIDTH-1:0]    rd_data,
    output logic [HEIGHT-1:0]   full_rows
);

    localparam logic [ROW_BITS-1:0] last_row = ROW_BITS'(HEIGHT - 1);
    localparam logic [COL_BITS-1:0] last_col = COL_BITS'(WIDTH - 1);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_clear = 2'd1;
`ifdef ROW_COLLAPSE_EN
    localparam logic [1:0] st_copy  = 2'd2;
    localparam logic [1:0] st_fill  = 2'd3;
`endif

    // Two complete boards; mem[front_sel] is displayed, mem[~front_sel] is edited.
    logic [WIDTH-1:0]    mem [2][HEIGHT];

    logic [1:0]          state;
    logic [ROW_BITS-1:0] ptr;        // CLEAR row, or COPY source row
    logic                back_sel;
    logic                do_swap;
    logic                wr_ok;

    logic                mem_we;
    logic [ROW_BITS-1:0] mem_row;
    logic [WIDTH-1:0]    mem_data;
    logic [HEIGHT-1:0]   full_next;

`ifdef ROW_COLLAPSE_EN
    logic [ROW_BITS-1:0] dst;        // next row to receive a surviving row
    logic [ROW_BITS-1:0] cleared;    // full rows skipped so far
    logic [ROW_BITS-1:0] cleared_inc;
    logic                src_full;

    assign src_full    = &mem[back_sel][ptr];
    assign cleared_inc = cleared + ROW_BITS'(src_full);
`endif

    assign back_sel = ~front_sel;
    assign busy     = (state != st_idle);

    // Out-of-range cells are dropped; busy is implied because cell writes are
    // only honoured in IDLE.
    assign wr_ok = wr_en && (wr_row <= last_row) && (wr_col <= last_col);

    // A swap needs a frame boundary and an idle engine. Blocking on swap_ack
    // keeps the acknowledge from firing twice while the requester is still
    // dropping swap_req.
    assign do_swap = swap_req && frame_done && !busy && !swap_ack;

    // -----------------------------------------------------------------------
    // Back-buffer row write mux: one row written per cycle, from either the
    // cell-write port (read-modify-write of one row) or the FSM.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        mem_we   = 1'b0;
        mem_row  = '0;
        mem_data = '0;
        case (state)
            st_idle: begin
                if (wr_ok) begin
                    mem_we           = 1'b1;
                    mem_row          = wr_row;
                    mem_data         = mem[back_sel][wr_row];
                    mem_data[wr_col] = wr_val;
                end
            end
            st_clear: begin
                mem_we  = 1'b1;
                mem_row = ptr;
            end
`ifdef ROW_COLLAPSE_EN
            st_copy: begin
                // Surviving rows move down to dst; full rows are skipped.
                if (!src_full) begin
                    mem_we   = 1'b1;
                    mem_row  = dst;
                    mem_data = mem[back_sel][ptr];
                end
            end
            st_fill: begin
                mem_we  = 1'b1;
                mem_row = dst;
            end
`endif
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        full_next = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            full_next[r] = &mem[back_sel][r];
        end
    end

    // -----------------------------------------------------------------------
    // Board storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: both boards must read as empty straight out of reset, so this storage is reset flop by flop rather than left to power-up contents.
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < HEIGHT; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (mem_we) begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            mem[back_sel][mem_row] <= mem_data;
        end
    end

    // -----------------------------------------------------------------------
    // Swap control, display read port and full-row flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
            rd_data   <= '0;
            full_rows <= '0;
        end else begin
            front_sel <= front_sel ^ do_swap;
            swap_ack  <= do_swap;
            // Read uses the pre-swap front buffer on a swap edge.
            rd_data   <= (rd_row <= last_row) ? mem[front_sel][rd_row] : '0;
            full_rows <= full_next;
        end
    end

    // -----------------------------------------------------------------------
    // Clear / collapse FSM. The back buffer it works on is fixed for the whole
    // run because swaps are held off while busy; a swap on the start edge has
    // already taken effect when the first row is touched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= st_idle;
            ptr           <= '0;
`ifdef ROW_COLLAPSE_EN
            dst           <= '0;
            cleared       <= '0;
            lines_cleared <= '0;
`endif
        end else begin
            case (state)
                st_idle: begin
                    if (clr_start) begin
                        state <= st_clear;
                        ptr   <= '0;
                    end
`ifdef ROW_COLLAPSE_EN
                    else if (collapse_start) begin
                        state   <= st_copy;
                        ptr     <= last_row;
                        dst     <= last_row;
                        cleared <= '0;
                    end
`endif
                end
                st_clear: begin
                    if (ptr == last_row) begin
                        state <= st_idle;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
`ifdef ROW_COLLAPSE_EN
                st_copy: begin
                    if (!src_full) begin
                        dst <= dst - 1'b1;
                    end
                    cleared <= cleared_inc;
                    if (ptr == '0) begin
                        // With nothing removed there is no top gap to fill.
                        if (cleared_inc == '0) begin
                            state         <= st_idle;
                            lines_cleared <= '0;
                        end else begin
                            state <= st_fill;
                        end
                    end else begin
                        ptr <= ptr - 1'b1;
                    end
                end
                st_fill: begin
                    // dst counts down to row 0; exactly 'cleared' rows are zeroed.
                    if (dst == '0) begin
                        state         <= st_idle;
                        lines_cleared <= cleared;
                    end else begin
                        dst <= dst - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_board_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_board_frame_buffer
//
// Scoreboard bench for board_frame_buffer. Stimulus pushes hand-computed
// expectations tagged with the clock edge at which they must hold; a monitor
// samples on the falling edge, pops matching entries and compares. swap_ack
// is tracked in its own queue so unexpected acknowledges are caught too.
// Define ROW_COLLAPSE_EN to build against the collapse variant.
// ---------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_board_frame_buffer;

    localparam int WIDTH    = 10;
    localparam int HEIGHT   = 20;
    localparam int ROW_BITS = 5;
    localparam int COL_BITS = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wr_en = 1'b0;
    logic [ROW_BITS-1:0] wr_row = '0;
    logic [COL_BITS-1:0] wr_col = '0;
    logic                wr_val = 1'b0;
    logic                clr_start = 1'b0;
    logic                busy;
    logic                swap_req = 1'b0;
    logic                frame_done = 1'b0;
    logic                swap_ack;
    logic                front_sel;
    logic [ROW_BITS-1:0] rd_row = '0;
    logic [WIDTH-1:0]    rd_data;
    logic [HEIGHT-1:0]   full_rows;
`ifdef ROW_COLLAPSE_EN
    logic                collapse_start = 1'b0;
    logic [ROW_BITS-1:0] lines_cleared;
`endif

    board_frame_buffer #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_row         (wr_row),
        .wr_col         (wr_col),
        .wr_val         (wr_val),
        .clr_start      (clr_start),
`ifdef ROW_COLLAPSE_EN
        .collapse_start (collapse_start),
        .lines_cleared  (lines_cleared),
`endif
        .busy           (busy),
        .swap_req       (swap_req),
        .frame_done     (frame_done),
        .swap_ack       (swap_ack),
        .front_sel      (front_sel),
        .rd_row         (rd_row),
        .rd_data        (rd_data),
        .full_rows      (full_rows)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; stable between edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_RD, K_FRONT, K_BUSY, K_FULL, K_LINES} kind_t;

    typedef struct {
        int          at;
        kind_t       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, want, cyc);
    endtask

    function automatic logic [31:0] sample(input kind_t k);
        case (k)
            K_RD:    return 32'(rd_data);
            K_FRONT: return 32'(front_sel);
            K_BUSY:  return 32'(busy);
            K_FULL:  return 32'(full_rows);
`ifdef ROW_COLLAPSE_EN
            K_LINES: return 32'(lines_cleared);
`endif
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: compare everything due at this edge, away from the clock edge.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at == cyc) begin
                check(exp_q[i].name, sample(exp_q[i].kind), exp_q[i].val);
                exp_q.delete(i);
            end
        end
        if (ack_q.size() > 0 && ack_q[0] == cyc) begin
            check("swap_ack pulse", 32'(swap_ack), 32'd1);
            void'(ack_q.pop_front());
        end else if (swap_ack) begin
            check("unexpected swap_ack", 32'(swap_ack), 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input kind_t k, input logic [31:0] v, input string name);
        exp_t e;
        e.at   = cyc + dly;
        e.kind = k;
        e.val  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic write_cell(input int r, input int c, input logic v);
        wr_row = ROW_BITS'(r);
        wr_col = COL_BITS'(c);
        wr_val = v;
        wr_en  = 1'b1;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic read_row(input int r, input logic [31:0] want, input string name);
        rd_row = ROW_BITS'(r);
        expect_at(1, K_RD, want, name);
        step();
    endtask

    task automatic do_swap(input logic new_front, input string name);
        swap_req   = 1'b1;
        frame_done = 1'b1;
        ack_q.push_back(cyc + 1);
        expect_at(1, K_FRONT, 32'(new_front), name);
        step();
        swap_req   = 1'b0;
        frame_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;

        // ---------------- reset ----------------
        step();
        expect_at(1, K_FRONT, 0, "reset front_sel");
        expect_at(1, K_BUSY,  0, "reset busy");
        expect_at(1, K_RD,    0, "reset rd_data");
        expect_at(1, K_FULL,  0, "reset full_rows");
`ifdef ROW_COLLAPSE_EN
        expect_at(1, K_LINES, 0, "reset lines_cleared");
`endif
        step();
        reset = 1'b0;

        // ---------------- write + first swap ----------------
        rd_row = 5'd3;
        expect_at(1, K_RD, 0, "row3 of front before swap");
        write_cell(3, 4, 1'b1);
        do_swap(1'b1, "front_sel after first swap");
        read_row(3, 32'h010, "row3 after swap");
        read_row(4, 32'h000, "row4 after swap");
        read_row(31, 32'h000, "out-of-range rd_row");

        // ---------------- swap_req held without frame_done ----------------
        swap_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 0) expect_at(1, K_FRONT, 1, "front held without frame_done");
            step();
        end
        frame_done = 1'b1;
        ack_q.push_back(cyc + 1);
        expect_at(1, K_FRONT, 0, "swap on frame_done after 50 cycles");
        step();
        frame_done = 1'b0;
        swap_req   = 1'b0;

        frame_done = 1'b1;
        expect_at(1, K_FRONT, 0, "frame_done alone does nothing");
        step();
        frame_done = 1'b0;

        // Both held for two edges: only one ack, one toggle.
        swap_req   = 1'b1;
        frame_done = 1'b1;
        ack_q.push_back(cyc + 1);
        expect_at(1, K_FRONT, 1, "swap with held request");
        step();
        expect_at(1, K_FRONT, 1, "no back-to-back swap");
        step();
        swap_req   = 1'b0;
        frame_done = 1'b0;

        // ---------------- full row flags (back = buffer 0) ----------------
        for (int c = 0; c < 9; c++) write_cell(19, c, 1'b1);
        expect_at(1, K_FULL, 0, "full19 on last-write edge");
        expect_at(2, K_FULL, 32'h80000, "full19 one cycle after last write");
        write_cell(19, 9, 1'b1);
        expect_at(1, K_FULL, 32'h80000, "full19 on clearing-write edge");
        expect_at(2, K_FULL, 0, "full19 after one cell cleared");
        write_cell(19, 5, 1'b0);
        write_cell(20, 0, 1'b1);
        write_cell(0, 12, 1'b1);
        write_cell(0, 9, 1'b1);
        do_swap(1'b0, "front_sel back to 0");
        read_row(19, 32'h3df, "row19 with col5 cleared");
        read_row(0, 32'h200, "row0 only col9");
        read_row(3, 32'h000, "row3 of buffer 0");

        // ---------------- clear of back buffer 1 ----------------
        c0 = cyc;
        clr_start = 1'b1;
        expect_at(1,  K_BUSY, 1, "busy on clear start edge");
        expect_at(10, K_BUSY, 1, "busy mid clear");
        expect_at(20, K_BUSY, 1, "busy last clear cycle");
        expect_at(21, K_BUSY, 0, "busy drops after 20 cycles");
        expect_at(21, K_FRONT, 0, "no swap without new frame_done");
        step();
        step();                        // clr_start held while busy
        clr_start = 1'b0;
        write_cell(3, 0, 1'b1);        // ignored: busy
        swap_req   = 1'b1;
        frame_done = 1'b1;
        expect_at(1, K_FRONT, 0, "swap deferred while busy");
        step();
        frame_done = 1'b0;
        while (cyc < c0 + 22) step();
        frame_done = 1'b1;
        ack_q.push_back(cyc + 1);
        expect_at(1, K_FRONT, 1, "deferred swap after busy");
        step();
        frame_done = 1'b0;
        swap_req   = 1'b0;
        read_row(3, 32'h000, "row3 cleared and busy write ignored");

        // ---------------- swap + clear + write on one edge ----------------
        // back = buffer 0: write lands there, clear hits new back (buffer 1).
        swap_req   = 1'b1;
        frame_done = 1'b1;
        clr_start  = 1'b1;
        wr_row = 5'd19; wr_col = 4'd5; wr_val = 1'b1; wr_en = 1'b1;
        ack_q.push_back(cyc + 1);
        expect_at(1,  K_FRONT, 0, "swap wins over clear start");
        expect_at(1,  K_BUSY,  1, "clear starts on swap edge");
        expect_at(21, K_BUSY,  0, "clear after swap lasts 20");
        step();
        swap_req = 1'b0; frame_done = 1'b0; clr_start = 1'b0; wr_en = 1'b0;
        repeat (20) step();
        read_row(19, 32'h3ff, "swap-edge write went to old back");
        read_row(0, 32'h200, "old back untouched by clear");

        // ---------------- reset during CLEAR ----------------
        write_cell(7, 2, 1'b1);        // buffer 1
        do_swap(1'b1, "front to buffer 1");
        expect_at(1, K_FULL, 32'h80000, "full_rows follows new back");
        read_row(7, 32'h004, "row7 of buffer 1");
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        expect_at(1, K_BUSY,  0, "busy after mid-clear reset");
        expect_at(1, K_FRONT, 0, "front_sel after mid-clear reset");
        expect_at(1, K_RD,    0, "rd_data after mid-clear reset");
        expect_at(1, K_FULL,  0, "full_rows after mid-clear reset");
        step();
        reset = 1'b0;
        read_row(19, 32'h000, "buffer 0 row19 zero after reset");
        do_swap(1'b1, "swap after reset");
        read_row(7, 32'h000, "buffer 1 row7 zero after reset");

`ifdef ROW_COLLAPSE_EN
        // ---------------- collapse (back = buffer 0) ----------------
        for (int c = 0; c < 10; c++) write_cell(19, c, 1'b1);
        for (int c = 0; c < 10; c++) write_cell(17, c, 1'b1);
        write_cell(18, 0, 1'b1);
        write_cell(16, 9, 1'b1);
        c0 = cyc;
        collapse_start = 1'b1;
        expect_at(1,  K_FULL,  32'ha0000, "rows 19 and 17 full");
        expect_at(1,  K_BUSY,  1, "busy on collapse start");
        expect_at(1,  K_LINES, 0, "lines_cleared holds during collapse");
        expect_at(22, K_BUSY,  1, "busy last collapse cycle");
        expect_at(23, K_BUSY,  0, "collapse busy 22 cycles");
        expect_at(23, K_LINES, 2, "lines_cleared after collapse");
        step();
        collapse_start = 1'b0;
        while (cyc < c0 + 23) step();
        do_swap(1'b0, "show collapsed board");
        read_row(19, 32'h001, "collapsed row19");
        read_row(18, 32'h200, "collapsed row18");
        read_row(17, 32'h000, "collapsed row17");
        read_row(1, 32'h000, "collapsed row1");
        read_row(0, 32'h000, "collapsed row0");

        // clr_start and collapse_start together: clear wins (back = buffer 1).
        for (int c = 0; c < 10; c++) write_cell(0, c, 1'b1);
        c0 = cyc;
        clr_start      = 1'b1;
        collapse_start = 1'b1;
        expect_at(20, K_BUSY,  1, "clear-wins still busy");
        expect_at(21, K_BUSY,  0, "clear-wins 20 cycles");
        expect_at(21, K_LINES, 2, "clear keeps lines_cleared");
        step();
        clr_start      = 1'b0;
        collapse_start = 1'b0;
        while (cyc < c0 + 21) step();
        do_swap(1'b1, "show cleared buffer 1");
        read_row(0, 32'h000, "row0 cleared by clear-wins");
`endif

        repeat (3) step();
        check("pending expectations", 32'(exp_q.size()), 32'd0);
        check("pending swap_acks", 32'(ack_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
